execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage plus EX/MEM pipeline register; feeds the memory stage (RegWriteM, MemtoRegM, MemWriteM, WriteRegM, WriteDataM, ALUOutM).
//  Selects forwarded operands, runs the ALU, drives ZeroE to branch logic.
//  With MULDIV_EN, executes MUL on an iterative shift-add unit and stalls the front end until the product is ready.
// PARAMETERS
//  XLEN     32  datapath width
//  MUL_ITER 32  shift-add iterations per MUL (= XLEN)
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset; synchronous, active-high
//  flush_e      in   1     squash the instruction in EX (bubble into EX/MEM)
//  RegWriteE    in   1     control from ID/EX
//  MemtoRegE    in   1     control from ID/EX
//  MemWriteE    in   1     control from ID/EX
//  ALUSrcE      in   1     1: SrcB = ImmE, 0: SrcB = forwarded RD2
//  ALUControlE  in   3     ALU opcode (see BEHAVIOUR)
//  RD1E, RD2E   in   XLEN  register-file operands
//  ImmE         in   XLEN  sign-extended immediate
//  WriteRegE    in   5     destination register
//  ForwardAE    in   2     operand-A select from hazard unit
//  ForwardBE    in   2     operand-B select from hazard unit
//  ResultW      in   XLEN  writeback result (forward source)
//  ALUOutM_fwd  in   XLEN  ALUOutM fed back (forward source)
//  ZeroE        out  1     combinational: ALU result == 0
//  stall_ex     out  1     hold PC, IF/ID, ID/EX this cycle
//  RegWriteM, MemtoRegM, MemWriteM  out 1 each  registered controls
//  WriteRegM    out  5     registered destination
//  WriteDataM   out  XLEN  registered forwarded RD2 (store data)
//  ALUOutM      out  XLEN  registered ALU / MUL result
// BEHAVIOUR
//  Forward select: 00 RDxE, 01 ResultW, 10 ALUOutM_fwd, 11 RDxE.
//  SrcA = fwdA; SrcB = ALUSrcE ? ImmE : fwdB; WriteDataE = fwdB.
//  ALU: 000 AND; 001 OR; 010 ADD; 011 XOR; 100 SLL by SrcB[4:0]; 101 MUL (low XLEN bits);
//       110 SUB; 111 SLT (signed, result 0/1). All arithmetic mod 2^XLEN, no flags but ZeroE.
//  EX/MEM register, posedge clk, priority order:
//    rst: all outputs 0.
//    flush_e or stall_ex: RegWriteM, MemtoRegM, MemWriteM <= 0 (bubble); data fields load don't-care.
//    else: all fields load EX values, 1-cycle latency.
//  Non-MUL ops: stall_ex = 0.
//  MUL FSM (MULDIV_EN):
//    IDLE: op==101 && !flush_e -> latch SrcA (mcand), SrcB (mplier), acc=0, cnt=0; go BUSY.
//          stall_ex = 1 combinationally in this issue cycle.
//    BUSY: stall_ex = 1. Each cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
//          cnt == MUL_ITER-1 -> DONE. flush_e -> IDLE (abort, stall drops next cycle).
//    DONE: stall_ex = 0; EX/MEM loads acc plus ID/EX controls (still held); -> IDLE without reissuing.
//  Timing: MUL seen in cycle T -> stall_ex high T..T+32 (33 cycles); ALUOutM valid after edge ending T+33.
//  Operands are latched at issue, so later ResultW/ALUOutM changes while stalled are ignored.
//  rst mid-MUL -> IDLE, stall_ex 0 next cycle.
//  Back-to-back MULs: second issues in the cycle after DONE.
// CONFIGURATION
//  MULDIV_EN defined: iterative multiplier and FSM present, behaving as above.
//  MULDIV_EN undefined: op 101 yields 0 with 1-cycle latency; stall_ex tied 0; no FSM logic.
// STRUCTURE
//  exec_pkg: ALU opcode localparams (ALU_AND..ALU_SLT), forward-select encodings (FWD_REG/FWD_WB/FWD_MEM),
//            MUL FSM state encodings.
//  Sub-module iter_multiplier (start, flush, a, b -> busy, done, product), instantiated only under MULDIV_EN.
//  ALU, forward muxes and EX/MEM register stay in execute_stage.
// TESTING
//  Sequence: rst=1 two cycles -> all M outputs 0, stall_ex 0; ADD RD1=5, RD2=7, ALUSrc=0 -> ALUOutM=12 next cycle.
//  Forwarding: ForwardAE=10, ALUOutM_fwd=0x10, ForwardBE=01, ResultW=3, op SUB -> ALUOutM=0x0D; WriteDataM=3.
//  SLT -1 vs 1 -> 1; SLL 1 by 31 -> 0x80000000; SUB 4-4 -> ZeroE=1.
//  flush_e=1 on a MemWrite=1 store -> MemWriteM=0 and RegWriteM=0 next cycle.
//  MULDIV_EN: MUL 0xFFFFFFFF*3 at T -> stall_ex 33 cycles; ALUOutM=0xFFFFFFFD after T+33; single RegWriteM pulse.
//  MULDIV_EN: rst asserted at T+10 of a MUL -> stall_ex 0 next cycle, no RegWriteM pulse; new MUL 6*7 -> 42.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forward selects and
// the iterative multiplier FSM states.
package exec_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low XLEN
// bits of the product. Only instantiated when MULDIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// BUSY  | accumulating, one multiplier bit per cycle
// DONE  | product valid for one cycle, then back to IDLE
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    mul_state_t      state;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MUL_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start && !flush) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (flush) begin
                        state <= MUL_IDLE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= MUL_DONE;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU and the EX/MEM pipeline register.
// Define MULDIV_EN to execute MUL on the iterative multiplier with a front-end stall.
module execute_stage
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_e,
    input  logic            RegWriteE,
    input  logic            MemtoRegE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmE,
    input  logic [4:0]      WriteRegE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUOutM_fwd,
    output logic            ZeroE,
    output logic            stall_ex,
    output logic            RegWriteM,
    output logic            MemtoRegM,
    output logic            MemWriteM,
    output logic [4:0]      WriteRegM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALUOutM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mul_result;

    always_comb begin
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUOutM_fwd;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUOutM_fwd;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmE : fwd_b;

`ifdef MULDIV_EN
    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    // No issue while in reset so a MUL held in ID/EX cannot restart the unit.
    assign mul_start = (ALUControlE == ALU_MUL) && !flush_e && !rst;

    iter_multiplier #(
        .XLEN     (XLEN),
        .MUL_ITER (MUL_ITER)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .flush   (flush_e),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_result = mul_product;
    // Stall in the issue cycle (IDLE + start) and throughout BUSY; DONE releases.
    assign stall_ex   = mul_busy || (mul_start && !mul_done);
`else
    assign mul_result = '0;
    assign stall_ex   = 1'b0;
`endif

    always_comb begin
        case (ALUControlE)
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLL: alu_result = src_a << src_b[4:0];
            ALU_MUL: alu_result = mul_result;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign ZeroE = (alu_result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            WriteRegM  <= '0;
            WriteDataM <= '0;
            ALUOutM    <= '0;
        end else begin
            if (flush_e || stall_ex) begin
                RegWriteM <= 1'b0;
                MemtoRegM <= 1'b0;
                MemWriteM <= 1'b0;
            end else begin
                RegWriteM <= RegWriteE;
                MemtoRegM <= MemtoRegE;
                MemWriteM <= MemWriteE;
            end
            WriteRegM  <= WriteRegE;
            WriteDataM <= fwd_b;
            ALUOutM    <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; MUL sequences are exercised when MULDIV_EN is defined.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_e;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmE;
    logic [4:0]  WriteRegE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW, ALUOutM_fwd;
    logic        ZeroE, stall_ex;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] WriteDataM, ALUOutM;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush_e     (flush_e),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .MemWriteE   (MemWriteE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmE        (ImmE),
        .WriteRegE   (WriteRegE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .ALUOutM_fwd (ALUOutM_fwd),
        .ZeroE       (ZeroE),
        .stall_ex    (stall_ex),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .WriteRegM   (WriteRegM),
        .WriteDataM  (WriteDataM),
        .ALUOutM     (ALUOutM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one ALU instruction with no forwarding.
    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic src, input logic [31:0] imm);
        ALUControlE = op;
        RD1E        = a;
        RD2E        = b;
        ALUSrcE     = src;
        ImmE        = imm;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
    endtask

    initial begin
        int n;
        int pulses;

        rst = 1'b1; flush_e = 1'b0;
        RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1;
        drive_op(3'b010, 32'd5, 32'd7, 1'b0, 32'd0);
        WriteRegE = 5'd9; ResultW = 32'h0; ALUOutM_fwd = 32'h0;
        step();
        step();
        check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("rst_memtoreg", {31'd0, MemtoRegM}, 32'd0);
        check("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
        check("rst_writereg", {27'd0, WriteRegM}, 32'd0);
        check("rst_writedata", WriteDataM, 32'd0);
        check("rst_aluout", ALUOutM, 32'd0);
        check("rst_stall", {31'd0, stall_ex}, 32'd0);

        rst = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
        step();
        check("add_aluout", ALUOutM, 32'd12);
        check("add_regwrite", {31'd0, RegWriteM}, 32'd1);
        check("add_writereg", {27'd0, WriteRegM}, 32'd9);
        check("add_writedata", WriteDataM, 32'd7);

        drive_op(3'b110, 32'd100, 32'd200, 1'b0, 32'd0);
        ForwardAE = 2'b10; ALUOutM_fwd = 32'h10;
        ForwardBE = 2'b01; ResultW = 32'd3;
        step();
        check("fwd_sub_aluout", ALUOutM, 32'h0000000D);
        check("fwd_writedata", WriteDataM, 32'd3);

        drive_op(3'b000, 32'h0000F0F0, 32'h55, 1'b1, 32'h0000FF00);
        ForwardAE = 2'b11;
        step();
        check("and_imm", ALUOutM, 32'h0000F000);
        check("fwd11_writedata", WriteDataM, 32'h55);

        drive_op(3'b001, 32'h0F, 32'hF0, 1'b0, 32'd0);
        step();
        check("or", ALUOutM, 32'hFF);
        drive_op(3'b011, 32'hFF, 32'h0F, 1'b0, 32'd0);
        step();
        check("xor", ALUOutM, 32'hF0);

        drive_op(3'b111, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0);
        step();
        check("slt_neg_pos", ALUOutM, 32'd1);
        drive_op(3'b111, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0);
        step();
        check("slt_pos_neg", ALUOutM, 32'd0);

        drive_op(3'b100, 32'd1, 32'd31, 1'b0, 32'd0);
        step();
        check("sll_31", ALUOutM, 32'h80000000);
        drive_op(3'b100, 32'd1, 32'd0, 1'b1, 32'd33);
        step();
        check("sll_imm_wrap", ALUOutM, 32'd2);

        drive_op(3'b010, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0);
        #1;
        check("add_wrap_zero", {31'd0, ZeroE}, 32'd1);
        step();
        check("add_wrap", ALUOutM, 32'd0);

        drive_op(3'b110, 32'd4, 32'd4, 1'b0, 32'd0);
        #1;
        check("sub_zero", {31'd0, ZeroE}, 32'd1);
        drive_op(3'b110, 32'd5, 32'd4, 1'b0, 32'd0);
        #1;
        check("sub_nonzero", {31'd0, ZeroE}, 32'd0);

        RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1; flush_e = 1'b1;
        drive_op(3'b010, 32'd8, 32'd4, 1'b1, 32'd4);
        step();
        check("flush_memwrite", {31'd0, MemWriteM}, 32'd0);
        check("flush_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("flush_memtoreg", {31'd0, MemtoRegM}, 32'd0);

        flush_e = 1'b0; RegWriteE = 1'b0;
        step();
        check("store_memwrite", {31'd0, MemWriteM}, 32'd1);
        check("store_memtoreg", {31'd0, MemtoRegM}, 32'd1);
        check("store_regwrite", {31'd0, RegWriteM}, 32'd0);
        MemtoRegE = 1'b0; MemWriteE = 1'b0; RegWriteE = 1'b1;

`ifdef MULDIV_EN
        // MUL 0xFFFFFFFF * 3, operand A forwarded from ResultW then changed mid-stall.
        drive_op(3'b101, 32'h0, 32'd3, 1'b0, 32'd0);
        ForwardAE = 2'b01; ResultW = 32'hFFFFFFFF; WriteRegE = 5'd12;
        #1;
        check("mul_issue_stall", {31'd0, stall_ex}, 32'd1);
        n = 0; pulses = 0;
        while (stall_ex && n < 60) begin
            n++;
            step();
            ResultW = 32'd0;
            if (RegWriteM) pulses++;
        end
        check("mul_stall_cycles", n, 32'd33);
        check("mul_no_early_pulse", pulses, 32'd0);
        step();
        check("mul_product", ALUOutM, 32'hFFFFFFFD);
        check("mul_regwrite", {31'd0, RegWriteM}, 32'd1);
        check("mul_writereg", {27'd0, WriteRegM}, 32'd12);
        drive_op(3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        RegWriteE = 1'b0;
        #1;
        check("mul_no_reissue", {31'd0, stall_ex}, 32'd0);
        step();
        check("mul_single_pulse", {31'd0, RegWriteM}, 32'd0);

        // Reset in the middle of a MUL.
        RegWriteE = 1'b1;
        drive_op(3'b101, 32'd5, 32'd9, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        check("mul_rst_stall", {31'd0, stall_ex}, 32'd0);
        rst = 1'b0; RegWriteE = 1'b0;
        drive_op(3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (RegWriteM || stall_ex) pulses++;
        end
        check("mul_rst_quiet", pulses, 32'd0);

        RegWriteE = 1'b1;
        drive_op(3'b101, 32'd6, 32'd7, 1'b0, 32'd0);
        #1;
        n = 0;
        while (stall_ex && n < 60) begin
            n++;
            step();
        end
        check("mul2_stall_cycles", n, 32'd33);
        step();
        check("mul2_product", ALUOutM, 32'd42);
        drive_op(3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
`else
        drive_op(3'b101, 32'd6, 32'd7, 1'b0, 32'd0);
        WriteRegE = 5'd12;
        #1;
        check("mul_off_stall", {31'd0, stall_ex}, 32'd0);
        check("mul_off_zero", {31'd0, ZeroE}, 32'd1);
        step();
        check("mul_off_result", ALUOutM, 32'd0);
        check("mul_off_regwrite", {31'd0, RegWriteM}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
